// File: rtl/alu8_multibyte_seq.sv
// Byte-serial sequencer that runs an NBYTES*8-bit operation through an external 8-bit ALU.
// The operation is processed LSB first, and the carry is chained through a register between bytes.
module alu8_multibyte_seq #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         alu_s1,
    output logic         alu_s0,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic         alu_cin,
    input  logic [7:0]   alu_f,
    input  logic         alu_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_f,
    output logic         out_cout,
    output logic         out_zero
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [1:0]              op_q, op_d;
    logic [NBYTES-1:0][7:0]  a_q, a_d;
    logic [NBYTES-1:0][7:0]  b_q, b_d;
    logic [NBYTES-1:0][7:0]  result_q, result_d;
    logic                    carry_q, carry_d;
    logic [1:0]              alu_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            op_q     <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        carry_d   = carry_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_sel   = 2'b00;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        alu_cin   = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d  = S_BUSY;
                    idx_d    = '0;
                    op_d     = in_op;
                    a_d      = in_a;
                    b_d      = in_b;
                    result_d = '0;
                    // The carry register doubles as the byte-0 carry-in, so the
                    // incoming cin is loaded here. This also flushes any stale chain.
                    carry_d  = (in_op == 2'b00 || in_op == 2'b11) ? in_cin : 1'b0;
                end
            end

            S_BUSY: begin
                alu_a = a_q[idx_q];
                alu_b = b_q[idx_q];
                case (op_q)
                    2'b01: begin
                        alu_sel = 2'b01;
                    end
                    2'b10: begin
                        if (idx_q == '0) begin
                            alu_sel = 2'b10;
                        end else begin
                            // Upper bytes only ripple the increment carry.
                            alu_sel = 2'b11;
                            alu_b   = 8'h00;
                            alu_cin = carry_q;
                        end
                    end
                    default: begin
                        alu_sel = op_q;
                        alu_cin = carry_q;
                    end
                endcase
                result_d[idx_q] = alu_f;
                carry_d         = alu_cout;
                idx_d           = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end
            end

            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign alu_s1   = alu_sel[1];
    assign alu_s0   = alu_sel[0];
    assign out_f    = result_q;
    assign out_cout = (state_q == S_DONE) && (op_q != 2'b01) && carry_q;
    assign out_zero = (state_q == S_DONE) && (result_q == '0);

endmodule

// File: tb/tb_alu8_multibyte_seq.sv
// Bench for alu8_multibyte_seq: a byte-level ALU model closes the loop, and the
// results are checked against wide arithmetic computed directly from the operation definitions.
module tb_alu8_multibyte_seq;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        alu_s1, alu_s0;
    logic [7:0]  alu_a, alu_b;
    logic        alu_cin;
    logic [7:0]  alu_f;
    logic        alu_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_f;
    logic        out_cout;
    logic        out_zero;

    int total = 0;
    int bad   = 0;

    alu8_multibyte_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .alu_s1    (alu_s1),
        .alu_s0    (alu_s0),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_f     (alu_f),
        .alu_cout  (alu_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_cout  (out_cout),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // The 8-bit two-select ALU stage sitting next to the sequencer.
    always_comb begin
        alu_f    = 8'h00;
        alu_cout = 1'b0;
        case ({alu_s1, alu_s0})
            2'b00:   {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_cin};
            2'b01:   alu_f = ~alu_a;
            2'b10:   {alu_cout, alu_f} = {1'b0, alu_a} + 9'd1;
            default: {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Operand B and the initial carry that each op adds to A.
    function automatic logic [63:0] b_eff(input logic [1:0] op, input logic [31:0] b);
        case (op)
            2'b00:   return {32'd0, ~b};
            2'b11:   return {32'd0, b};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] c_eff(input logic [1:0] op, input logic cin);
        if (op == 2'b10) return 64'd1;
        if (op == 2'b01) return 64'd0;
        return {63'd0, cin};
    endfunction

    // Full-width result {cout, f}.
    function automatic logic [32:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        logic [63:0] s;
        if (op == 2'b01) return {1'b0, ~a};
        s = {32'd0, a} + b_eff(op, b) + c_eff(op, cin);
        return s[32:0];
    endfunction

    // Carry entering byte k when the wide sum is done in one piece.
    function automatic logic carry_into(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin, input int k);
        logic [63:0] mask;
        logic [63:0] s;
        mask = (64'd1 << (8 * k)) - 64'd1;
        s = ({32'd0, a} & mask) + (b_eff(op, b) & mask) + c_eff(op, cin);
        return s[8 * k];
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input int stall, input bit keep_valid);
        logic [32:0] exp;
        logic [7:0]  eb;
        logic [1:0]  es;
        logic        ec;
        exp = ref_op(op, a, b, cin);
        chk("idle_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        if (!keep_valid) in_valid = 1'b0;
        for (int k = 0; k < NB; k++) begin
            es = (op == 2'b10 && k > 0) ? 2'b11 : op;
            eb = (op == 2'b10 && k > 0) ? 8'h00 : b[8*k +: 8];
            if (op == 2'b01 || (op == 2'b10 && k == 0)) ec = 1'b0;
            else ec = carry_into(op, a, b, cin, k);
            chk("drive_sel", {alu_s1, alu_s0}, es);
            chk("drive_a", alu_a, a[8*k +: 8]);
            chk("drive_b", alu_b, eb);
            chk("drive_cin", alu_cin, ec);
            chk("busy_in_ready", in_ready, 0);
            chk("busy_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        chk("latency_out_valid", out_valid, 1);
        chk("out_f", out_f, exp[31:0]);
        chk("out_cout", out_cout, exp[32]);
        chk("out_zero", out_zero, exp[31:0] == 32'd0);
        chk("done_alu_idle", {alu_s1, alu_s0, alu_a, alu_b, alu_cin}, 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_f", out_f, exp[31:0]);
            chk("stall_out_cout", out_cout, exp[32]);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_hs_in_ready", in_ready, 1);
        chk("after_hs_out_valid", out_valid, 0);
        $display("op=%0d a=%08h b=%08h cin=%0d stall=%0d -> f=%08h cout=%0d zero=%0d",
                 op, a, b, cin, stall, exp[31:0], exp[32], exp[31:0] == 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_cin = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_f", out_f, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_alu", {alu_s1, alu_s0, alu_a, alu_b, alu_cin}, 0);

        run_op(2'b11, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0, 1'b0);
        run_op(2'b00, 32'h0000_0005, 32'h0000_0007, 1'b1, 0, 1'b0);
        run_op(2'b01, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);

        // Back-pressure with a second request already waiting.
        run_op(2'b11, 32'h8000_0001, 32'h8000_0003, 1'b1, 2, 1'b1);
        run_op(2'b11, 32'h8000_0001, 32'h8000_0003, 1'b1, 0, 1'b0);

        // Reset while BUSY at byte 2.
        in_valid = 1'b1; in_op = 2'b11; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_cin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_alu", {alu_s1, alu_s0, alu_a, alu_b, alu_cin}, 0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("midrst_no_valid", out_valid, 0);
        end
        run_op(2'b11, 32'h0000_0001, 32'h0000_0001, 1'b0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (t % 5 == 0) rb = ~ra;
            if (t % 7 == 0) ra = 32'hFFFF_FFFF;
            run_op(2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
